cc_vector_sequencer: RTL

Self-test sequencer for the 3-input combinational cell (inputs x, y, z; output d). On a start request it latches an expected 8-entry truth table. It then drives all eight input vectors {x,y,z} = 0..7 in ascending order into the cell, waits a settle interval per vector, samples d and records mismatches. It sits beside the cell under test, owns its inputs, and reports pass/fail plus a per-vector failure mask.

---
 rtl/cc_vector_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cc_vector_sequencer.sv
// ============================================================================
// Module   : cc_vector_sequencer
// Brief    : Exhaustive self-test sweep for a 3-input combinational cell.
//            Drives {x,y,z} = 0..7, samples d after a settle interval and
//            compares it against a latched 8-entry truth table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cc_vector_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] exp_tt,
    input  logic       d,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] fail_mask,
    output logic [3:0] fail_count
);

    localparam logic [3:0] c_cnt_last = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_vec, w_vec_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_exp, w_exp_nxt;
    logic [7:0] r_mask, w_mask_nxt;
    logic [3:0] r_count, w_count_nxt;
    logic       r_pass, w_pass_nxt;
    logic [2:0] r_xyz, w_xyz_nxt;
    logic       w_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_vec   <= 3'd0;
            r_cnt   <= 4'd0;
            r_exp   <= 8'd0;
            r_mask  <= 8'd0;
            r_count <= 4'd0;
            r_pass  <= 1'b0;
            r_xyz   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_cnt   <= w_cnt_nxt;
            r_exp   <= w_exp_nxt;
            r_mask  <= w_mask_nxt;
            r_count <= w_count_nxt;
            r_pass  <= w_pass_nxt;
            r_xyz   <= w_xyz_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_cnt_nxt   = r_cnt;
        w_exp_nxt   = r_exp;
        w_mask_nxt  = r_mask;
        w_count_nxt = r_count;
        w_pass_nxt  = r_pass;
        w_xyz_nxt   = r_xyz;
        // Written as if/else so an unknown d falls through as a mismatch
        w_hit = 1'b0;
        if (d == r_exp[r_vec]) begin
            w_hit = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_exp_nxt   = exp_tt;
                    w_mask_nxt  = 8'd0;
                    w_count_nxt = 4'd0;
                    w_pass_nxt  = 1'b0;
                    w_vec_nxt   = 3'd0;
                    w_cnt_nxt   = 4'd0;
                    w_xyz_nxt   = 3'd0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_pass_nxt  = 1'b0;
                    w_vec_nxt   = 3'd0;
                    w_cnt_nxt   = 4'd0;
                    w_xyz_nxt   = 3'd0;
                end else if (r_cnt == c_cnt_last) begin
                    if (!w_hit) begin
                        w_mask_nxt[r_vec] = 1'b1;
                        w_count_nxt       = r_count + 4'd1;
                    end
                    w_cnt_nxt = 4'd0;
                    if (r_vec == 3'd7) begin
                        w_state_nxt = ST_DONE;
                        w_vec_nxt   = 3'd0;
                        w_xyz_nxt   = 3'd0;
                        w_pass_nxt  = (w_mask_nxt == 8'd0);
                    end else begin
                        w_vec_nxt = r_vec + 3'd1;
                        w_xyz_nxt = r_vec + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_xyz_nxt   = 3'd0;
            end
        endcase
    end

    assign x          = r_xyz[2];
    assign y          = r_xyz[1];
    assign z          = r_xyz[0];
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign pass       = r_pass;
    assign fail_mask  = r_mask;
    assign fail_count = r_count;

endmodule

`default_nettype wire
